aes_text_out_unloader: RTL and testbench

Output-side reader for the AES cipher core. On the cipher's one-cycle `done` pulse it captures the 128-bit `text_out` result, then streams it to a downstream consumer as 128/WORD_W words over a valid/ready interface. It also flags any result that is lost because the previous block is still being streamed. It sits directly after `aes_cipher_top` and is the consumer of that core's `text_out` register bank.

---
 rtl/aes_text_out_unloader.sv | 100 ++++++++++
 tb/tb_aes_text_out_unloader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_text_out_unloader.sv
// rtl/aes_text_out_unloader.sv - captures the AES text_out block on done and streams it as WORD_W words
// Drops (and flags) any done that arrives before the last word of the current block is accepted.
module aes_text_out_unloader #(
  parameter int WORD_W    = 32,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [127:0]      text_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);
  localparam int NWORDS = 128 / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [127:0]       buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overrun_q, overrun_d;
  logic               is_last;
  logic               accept;
  logic [WORD_W-1:0]  word_sel;

  assign is_last = (idx_q == IDX_W'(NWORDS - 1));
  assign m_valid = (state_q == SEND);
  assign accept  = m_valid && m_ready;
  assign busy    = m_valid;
  assign m_last  = m_valid && is_last;
  assign m_data  = m_valid ? word_sel : '0;
  assign overrun = overrun_q;

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        word_sel = MSW_FIRST ? buf_q[127 - k*WORD_W -: WORD_W] : buf_q[k*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (done) begin
          buf_d   = text_out;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (is_last) begin
            idx_d = '0;
            // A done coincident with the final handshake chains the next block without a bubble.
            if (done) begin
              buf_d = text_out;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        if (done && !(accept && is_last)) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_aes_text_out_unloader.sv
// tb/tb_aes_text_out_unloader.sv - directed scoreboard bench for aes_text_out_unloader
// Instance a: WORD_W=32 MSW first; instance b: WORD_W=8 LSW first.
module tb_aes_text_out_unloader;
  localparam logic [127:0] T1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] T2 = 128'hffeeddcc_bbaa9988_77665544_33221100;

  logic clk = 1'b0;
  logic rst;

  logic         done_a, ready_a, clr_a;
  logic [127:0] text_a;
  logic         vld_a, last_a, busy_a, ovr_a;
  logic [31:0]  data_a;

  logic         done_b, ready_b, clr_b;
  logic [127:0] text_b;
  logic         vld_b, last_b, busy_b, ovr_b;
  logic [7:0]   data_b;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_a[$];
  logic [8:0]  exp_b[$];

  always #5 clk = ~clk;

  aes_text_out_unloader #(.WORD_W(32), .MSW_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .done(done_a), .text_out(text_a),
    .m_valid(vld_a), .m_ready(ready_a), .m_data(data_a), .m_last(last_a),
    .busy(busy_a), .overrun(ovr_a), .clr_overrun(clr_a)
  );

  aes_text_out_unloader #(.WORD_W(8), .MSW_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .done(done_b), .text_out(text_b),
    .m_valid(vld_b), .m_ready(ready_b), .m_data(data_b), .m_last(last_b),
    .busy(busy_b), .overrun(ovr_b), .clr_overrun(clr_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [127:0] t);
    for (int k = 0; k < 4; k++) exp_a.push_back({(k == 3), t[127 - 32*k -: 32]});
  endtask

  task automatic push_b(input logic [127:0] t);
    for (int k = 0; k < 16; k++) exp_b.push_back({(k == 15), t[8*k +: 8]});
  endtask

  // Compare every valid word against the scoreboard front; pop on handshake.
  task automatic step();
    @(negedge clk);
    if (exp_a.size() == 0) begin
      chk("a_spurious_valid", 128'(vld_a), 128'(0));
    end else if (vld_a) begin
      chk("a_data", 128'(data_a), 128'(exp_a[0][31:0]));
      chk("a_last", 128'(last_a), 128'(exp_a[0][32]));
      if (ready_a) void'(exp_a.pop_front());
    end
    if (exp_b.size() == 0) begin
      chk("b_spurious_valid", 128'(vld_b), 128'(0));
    end else if (vld_b) begin
      chk("b_data", 128'(data_b), 128'(exp_b[0][7:0]));
      chk("b_last", 128'(last_b), 128'(exp_b[0][8]));
      if (ready_b) void'(exp_b.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] bp_pat;
    rst = 1'b1;
    done_a = 1'b0; ready_a = 1'b0; clr_a = 1'b0; text_a = '0;
    done_b = 1'b0; ready_b = 1'b0; clr_b = 1'b0; text_b = '0;
    #2;
    chk("rst_valid_a", 128'(vld_a), 128'(0));
    chk("rst_data_a", 128'(data_a), 128'(0));
    chk("rst_last_a", 128'(last_a), 128'(0));
    chk("rst_busy_a", 128'(busy_a), 128'(0));
    chk("rst_ovr_a", 128'(ovr_a), 128'(0));
    chk("rst_valid_b", 128'(vld_b), 128'(0));
    chk("rst_data_b", 128'(data_b), 128'(0));
    chk("rst_busy_b", 128'(busy_b), 128'(0));
    chk("rst_ovr_b", 128'(ovr_b), 128'(0));
    step();
    rst = 1'b0;
    step();

    // Single block, ready held high: words on N+1..N+4, idle at N+5.
    ready_a = 1'b1; done_a = 1'b1; text_a = T1; push_a(T1);
    step();
    done_a = 1'b0;
    chk("single_busy", 128'(busy_a), 128'(1));
    chk("single_first_word", 128'(data_a), 128'(32'h00112233));
    for (int i = 0; i < 4; i++) step();
    chk("single_drained", 128'(exp_a.size()), 128'(0));
    chk("single_idle", 128'(vld_a), 128'(0));
    chk("single_idle_data", 128'(data_a), 128'(0));

    // Backpressure pattern 1,0,0,1,0,1,1.
    bp_pat = 7'b1001011;
    done_a = 1'b1; text_a = T1; push_a(T1);
    step();
    done_a = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      ready_a = bp_pat[i];
      step();
    end
    chk("bp_drained", 128'(exp_a.size()), 128'(0));
    chk("bp_idle", 128'(vld_a), 128'(0));

    // Back-to-back: next done coincident with the last handshake.
    ready_a = 1'b1; done_a = 1'b1; text_a = T1; push_a(T1);
    step();
    done_a = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("b2b_last_present", 128'(last_a), 128'(1));
    done_a = 1'b1; text_a = T2; push_a(T2);
    step();
    done_a = 1'b0;
    chk("b2b_next_word", 128'(data_a), 128'(32'hffeeddcc));
    chk("b2b_valid", 128'(vld_a), 128'(1));
    for (int i = 0; i < 4; i++) step();
    chk("b2b_drained", 128'(exp_a.size()), 128'(0));
    chk("b2b_no_overrun", 128'(ovr_a), 128'(0));
    chk("b2b_idle", 128'(vld_a), 128'(0));

    // Overrun: done while word 1 is stalled; set beats a coincident clear.
    done_a = 1'b1; text_a = T1; push_a(T1);
    step();
    done_a = 1'b0;
    step();
    ready_a = 1'b0; done_a = 1'b1; text_a = T2;
    step();
    done_a = 1'b0;
    chk("ovr_set", 128'(ovr_a), 128'(1));
    chk("ovr_hold_word", 128'(data_a), 128'(32'h44556677));
    done_a = 1'b1; clr_a = 1'b1;
    step();
    done_a = 1'b0; clr_a = 1'b0;
    chk("ovr_set_wins", 128'(ovr_a), 128'(1));
    ready_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("ovr_drained", 128'(exp_a.size()), 128'(0));
    chk("ovr_idle", 128'(vld_a), 128'(0));
    chk("ovr_sticky", 128'(ovr_a), 128'(1));
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    chk("ovr_cleared", 128'(ovr_a), 128'(0));

    // Reset mid-stream after word 1 is accepted, with overrun pending.
    done_a = 1'b1; text_a = T1; push_a(T1);
    step();
    done_a = 1'b0;
    step();
    done_a = 1'b1; text_a = T2;
    step();
    done_a = 1'b0;
    chk("mid_ovr_set", 128'(ovr_a), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(vld_a), 128'(0));
    chk("mid_rst_data", 128'(data_a), 128'(0));
    chk("mid_rst_ovr", 128'(ovr_a), 128'(0));
    chk("mid_rst_last", 128'(last_a), 128'(0));
    exp_a.delete();
    done_a = 1'b1;
    step();
    step();
    rst = 1'b0; done_a = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_idle", 128'(vld_a), 128'(0));
    done_a = 1'b1; text_a = T2; push_a(T2);
    step();
    done_a = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_drained", 128'(exp_a.size()), 128'(0));

    // WORD_W=8, LSW first: ff, ee, ..., 00.
    ready_b = 1'b1; done_b = 1'b1; text_b = T1; push_b(T1);
    step();
    done_b = 1'b0;
    chk("b_first_byte", 128'(data_b), 128'(8'hff));
    for (int i = 0; i < 16; i++) step();
    chk("b_drained", 128'(exp_b.size()), 128'(0));
    chk("b_idle", 128'(vld_b), 128'(0));
    chk("b_no_overrun", 128'(ovr_b), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
